// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
// Holds the FSM encoding, port indices, RV32 load/store funct3 codes and the default fairness bound.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned STARVE_MAX_DEF = 4;

  // Counter width able to hold the value max itself.
  function automatic int unsigned cnt_w(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshakes plus memory-side pins of the arbiter, bundled as one interface.
// slave = arbiter view, master = requesters and memory (testbench) view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [2:0]        funct3_0;
  logic [2:0]        funct3_1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_wen;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_ra;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  req0, req1, we0, we1, funct3_0, funct3_1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1,
    output mem_wen, mem_func3, mem_ra, mem_wa, mem_wd,
    input  mem_rd
  );

  modport master (
    output req0, req1, we0, we1, funct3_0, funct3_1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1,
    input  mem_wen, mem_func3, mem_ra, mem_wa, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/mem_arb_select.sv
// Combinational winner pick; MEM_ARB_ROUND_ROBIN_EN chooses round-robin, else port 0 priority with starvation escape.
// Zero latency; the FSM only consults it in IDLE, so a losing requester simply keeps waiting.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned CNT_W      = cnt_w(STARVE_MAX)
) (
  input  logic             req0,
  input  logic             req1,
  input  port_t            last_grant,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             gnt_vld,
  output port_t            gnt_port
);

  assign gnt_vld = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic unused_cnt;
  assign unused_cnt = (^starve_cnt) ^ (STARVE_MAX == 0);

  always_comb begin
    gnt_port = PORT0;
    if (req0 && req1) begin
      gnt_port = (last_grant == PORT0) ? PORT1 : PORT0;
    end else if (req1) begin
      gnt_port = PORT1;
    end
  end
`else
  logic unused_last;
  assign unused_last = (last_grant == PORT1);

  // Port 1 wins when alone, or once port 0 has been served STARVE_MAX times in a row over it.
  always_comb begin
    gnt_port = PORT0;
    if (req1 && (!req0 || (starve_cnt >= CNT_W'(STARVE_MAX)))) begin
      gnt_port = PORT1;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises single reads/writes from two requesters onto one memory; MEM_ARB_ROUND_ROBIN_EN picks round-robin arbitration.
// Write ack 2 cycles, read ack 3 cycles after req is seen in IDLE; requesters hold req and fields until their ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W   = cnt_w(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t            state_q,      state_d;
  port_t             port_q,       port_d;
  port_t             last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              ack0_q,       ack0_d;
  logic              ack1_q,       ack1_d;
  logic              mem_wen_q,    mem_wen_d;
  logic              is_wr_q,      is_wr_d;
  logic [2:0]        mem_func3_q,  mem_func3_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wd_q,     mem_wd_d;
  logic [DATA_W-1:0] rdata0_q,     rdata0_d;
  logic [DATA_W-1:0] rdata1_q,     rdata1_d;

  logic  gnt_vld;
  port_t gnt_port;

  mem_arb_select #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_select (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant_q),
    .starve_cnt (starve_cnt_q),
    .gnt_vld    (gnt_vld),
    .gnt_port   (gnt_port)
  );

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    mem_wen_d    = 1'b0;
    is_wr_d      = is_wr_q;
    mem_func3_d  = mem_func3_q;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (!bus.req1) begin
          starve_cnt_d = '0;
        end
        if (gnt_vld) begin
          state_d      = ISSUE;
          port_d       = gnt_port;
          last_grant_d = gnt_port;
          // The memory pins double as the transaction latch; the write ack is
          // registered here so it lands in the ISSUE cycle.
          if (gnt_port == PORT1) begin
            is_wr_d      = bus.we1;
            mem_wen_d    = bus.we1;
            mem_func3_d  = bus.funct3_1;
            mem_addr_d   = bus.addr1;
            mem_wd_d     = bus.wdata1;
            ack1_d       = bus.we1;
            starve_cnt_d = '0;
          end else begin
            is_wr_d     = bus.we0;
            mem_wen_d   = bus.we0;
            mem_func3_d = bus.funct3_0;
            mem_addr_d  = bus.addr0;
            mem_wd_d    = bus.wdata0;
            ack0_d      = bus.we0;
            if (bus.req1 && (starve_cnt_q != CNT_MAX)) begin
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      ISSUE: begin
        if (is_wr_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RD;
          ack0_d  = (port_q == PORT0);
          ack1_d  = (port_q == PORT1);
        end
      end

      WAIT_RD: begin
        state_d = IDLE;
        if (port_q == PORT0) begin
          rdata0_d = bus.mem_rd;
        end else begin
          rdata1_d = bus.mem_rd;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      port_q       <= PORT0;
      last_grant_q <= PORT1;
      starve_cnt_q <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_wen_q    <= 1'b0;
      is_wr_q      <= 1'b0;
      mem_func3_q  <= '0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      mem_wen_q    <= mem_wen_d;
      is_wr_q      <= is_wr_d;
      mem_func3_q  <= mem_func3_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Memory read data only arrives in the ack cycle, so forward it until it is captured.
  assign bus.rdata0 = (state_q == WAIT_RD && port_q == PORT0) ? bus.mem_rd : rdata0_q;
  assign bus.rdata1 = (state_q == WAIT_RD && port_q == PORT1) ? bus.mem_rd : rdata1_q;

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_func3 = mem_func3_q;
  assign bus.mem_ra    = mem_addr_q;
  assign bus.mem_wa    = mem_addr_q;
  assign bus.mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory + LED register model.
// Build with MEM_ARB_ROUND_ROBIN_EN to check the round-robin grant order instead.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] LED_ADDR = 32'h0000_2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:1023];
  logic [7:0]  led;
  int errors = 0;
  int checks = 0;
  int dual_acks = 0;

  // Synchronous memory: write at the edge that ends ISSUE, read data one cycle after address.
  always @(posedge clk) begin
    if (bus.mem_wen) begin
      if (bus.mem_wa == LED_ADDR) begin
        led <= bus.mem_wd[7:0];
      end else if (bus.mem_func3 == F3_SB) begin
        mem[bus.mem_wa[11:2]][{bus.mem_wa[1:0], 3'b000} +: 8] <= bus.mem_wd[7:0];
      end else if (bus.mem_func3 == F3_SH) begin
        mem[bus.mem_wa[11:2]][{bus.mem_wa[1], 4'b0000} +: 16] <= bus.mem_wd[15:0];
      end else begin
        mem[bus.mem_wa[11:2]] <= bus.mem_wd;
      end
    end
    bus.mem_rd <= mem[bus.mem_ra[11:2]];
  end

  always @(negedge clk) begin
    if (bus.ack0 && bus.ack1) dual_acks++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int port, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    if (port == 0) begin
      bus.we0 = we; bus.funct3_0 = f3; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.funct3_1 = f3; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
    end
  endtask

  task automatic drop_all();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  // Single read; latency counts the IDLE cycle in which req is first seen as cycle 1.
  task automatic read_txn(input int port, input logic [31:0] a, input logic [31:0] exp_rd,
                          input string tag);
    int lat = 0;
    logic [31:0] rd = '0;
    start(port, 1'b0, F3_LW, a, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if ((port == 0 && bus.ack0) || (port == 1 && bus.ack1)) begin
        lat = c + 1;
        rd  = (port == 0) ? bus.rdata0 : bus.rdata1;
        break;
      end
    end
    drop_all();
    check({tag, "_lat"}, lat, 3);
    check({tag, "_rdata"}, rd, exp_rd);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int n;
    int first;
    logic [9:0] seq;
    logic [9:0] exp_seq;

    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | i;
    led = 8'h00;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.funct3_0 = 0; bus.funct3_1 = 0; bus.addr0 = 0; bus.addr1 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0;

    // 1: reset values, then quiet after release
    tick(); tick();
    check("rst_ack0", bus.ack0, 0);
    check("rst_ack1", bus.ack1, 0);
    check("rst_wen", bus.mem_wen, 0);
    check("rst_f3", bus.mem_func3, 0);
    check("rst_ra", bus.mem_ra, 0);
    check("rst_wa", bus.mem_wa, 0);
    check("rst_wd", bus.mem_wd, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ack0 || bus.ack1 || bus.mem_wen) acks++;
    end
    check("idle_quiet", acks, 0);

    // 2: port 0 word write then read back
    start(0, 1'b1, F3_SW, 32'h100, 32'hA5A5_A5A5);
    tick();
    check("wr_wen", bus.mem_wen, 1);
    check("wr_f3", bus.mem_func3, F3_SW);
    check("wr_wa", bus.mem_wa, 32'h100);
    check("wr_wd", bus.mem_wd, 32'hA5A5_A5A5);
    check("wr_ack0", bus.ack0, 1);
    drop_all();
    tick();
    check("wr_wen_off", bus.mem_wen, 0);
    check("wr_ack_off", bus.ack0, 0);
    read_txn(0, 32'h100, 32'hA5A5_A5A5, "rd0");
    check("rd0_hold", bus.rdata0, 32'hA5A5_A5A5);

    // 3: both ports streaming reads from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    start(0, 1'b0, F3_LW, 32'h100, 32'h0);
    start(1, 1'b0, F3_LW, 32'h104, 32'h0);
    n = 0;
    seq = '0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      tick();
      if (bus.ack0) begin
        seq[n] = 1'b0;
        check("str_rdata0", bus.rdata0, 32'hA5A5_A5A5);
        n++;
      end else if (bus.ack1) begin
        seq[n] = 1'b1;
        check("str_rdata1", bus.rdata1, 32'hC000_0041);
        n++;
      end
    end
    drop_all();
    tick(); tick();
    check("str_count", n, 10);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = 10'b10_1010_1010;
`else
    exp_seq = 10'b10_0001_0000;
`endif
    check("str_order", seq, exp_seq);
    check("str_dual", dual_acks, 0);

    // 4: port 1 byte store to the LED register
    start(1, 1'b1, F3_SB, LED_ADDR, 32'hDEAD_BE12);
    tick();
    check("led_wen", bus.mem_wen, 1);
    check("led_f3", bus.mem_func3, F3_SB);
    check("led_wa", bus.mem_wa, LED_ADDR);
    check("led_ack1", bus.ack1, 1);
    check("led_ack0", bus.ack0, 0);
    drop_all();
    tick();
    check("led_value", led, 8'h12);
    check("led_rdata1_hold", bus.rdata1, 32'hC000_0041);

    // 5: reset during port 1 read wait
    start(1, 1'b0, F3_LW, 32'h104, 32'h0);
    tick();
    check("abort_issue_ack1", bus.ack1, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_ack1", bus.ack1, 0);
    check("abort_wen", bus.mem_wen, 0);
    check("abort_rdata1", bus.rdata1, 0);
    drop_all();
    tick();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ack0 || bus.ack1) acks++;
    end
    check("abort_no_ack", acks, 0);
    read_txn(0, 32'h100, 32'hA5A5_A5A5, "post_abort");

    // 5b: reset while a write is in ISSUE drops mem_wen at once
    start(0, 1'b1, F3_SW, 32'h108, 32'h1111_1111);
    tick();
    check("wabort_wen_pre", bus.mem_wen, 1);
    #1 reset = 1'b1;
    #1;
    check("wabort_wen", bus.mem_wen, 0);
    check("wabort_ack0", bus.ack0, 0);
    drop_all();
    tick();
    reset = 1'b0;
    tick();

    // 6: req0 dropped right after being latched
    start(0, 1'b0, F3_LW, 32'h100, 32'h0);
    tick();
    drop_all();
    acks = 0;
    first = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (bus.ack0) begin
        acks++;
        if (first == 0) first = i;
      end
    end
    check("drop_ack_count", acks, 1);
    check("drop_ack_cycle", first, 1);
    check("drop_rdata0", bus.rdata0, 32'hA5A5_A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
